// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight at a time,
// and loads the IF/ID register, with a one-entry skid buffer for responses that arrive under stall.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_plus4_q;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;

    logic        can_load_s;
    logic        req_fire_s;
    logic        outstanding_s;
    logic        load_s;
    logic [31:0] load_instr_s;

    // Reset gates the request so a state already forced to FETCH cannot fire while reset is held.
    assign imem_req_valid = (state_q == S_FETCH) && !reset;
    assign imem_req_addr  = pc_q;

    assign can_load_s    = !stall || !ifid_valid_q;
    assign req_fire_s    = imem_req_valid && imem_req_ready;
    assign outstanding_s = ((state_q == S_WAIT)  && !imem_resp_valid) ||
                           ((state_q == S_FETCH) && req_fire_s)       ||
                           ((state_q == S_DRAIN) && !imem_resp_valid);

    assign ifid_valid    = ifid_valid_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;

    // Next-state, PC, skid buffer and IF/ID update; redirect overrides every state action.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        buf_valid_d  = buf_valid_q;
        buf_instr_d  = buf_instr_q;
        load_s       = 1'b0;
        load_instr_s = buf_instr_q;

        if (redirect_valid) begin
            pc_d         = redirect_pc & 32'hFFFF_FFFC;
            ifid_valid_d = 1'b0;
            buf_valid_d  = 1'b0;
            if (outstanding_s) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (req_fire_s) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid && can_load_s) begin
                        load_s       = 1'b1;
                        load_instr_s = imem_resp_data;
                        pc_d         = pc_q + 32'd4;
                        state_d      = S_FETCH;
                    end else if (imem_resp_valid) begin
                        buf_valid_d = 1'b1;
                        buf_instr_d = imem_resp_data;
                        state_d     = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (buf_valid_q && can_load_s) begin
                        load_s      = 1'b1;
                        buf_valid_d = 1'b0;
                        pc_d        = pc_q + 32'd4;
                        state_d     = S_FETCH;
                    end else if (!buf_valid_q) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase

            // No new instruction: a free decode stage sees a bubble, a stalled one keeps its entry.
            if (load_s) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = pc_q;
                ifid_instr_d = load_instr_s;
            end else if (!stall) begin
                ifid_valid_d = 1'b0;
            end else begin
                ifid_valid_d = ifid_valid_q;
            end
        end
    end

    // State, PC, skid buffer and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_FETCH;
            pc_q            <= RESET_PC;
            ifid_valid_q    <= 1'b0;
            ifid_pc_q       <= 32'h0000_0000;
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_plus4_q <= 32'h0000_0004;
            buf_valid_q     <= 1'b0;
            buf_instr_q     <= NOP_INSTR;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus4_q <= ifid_pc_d + 32'd4;
            buf_valid_q     <= buf_valid_d;
            buf_instr_q     <= buf_instr_d;
        end
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RV32I pipeline: holds the PC, issues one instruction-memory request at a time, and loads the IF/ID pipeline register that feeds the decode stage. Honours a hazard stall from downstream and a branch/jump redirect from the execute stage. On a redirect it flushes the IF/ID entry and discards any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset (bits [1:0] must be 0)
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  32  fetch address (current PC)
- imem_req_ready  input  1  memory accepts request this cycle
- imem_resp_valid  input  1  instruction word returned this cycle
- imem_resp_data  input  32  instruction word
- stall  input  1  decode cannot accept; hold IF/ID
- redirect_valid  input  1  taken branch/jump from EX
- redirect_pc  input  32  redirect target
- ifid_valid  output  1  IF/ID entry holds a real instruction
- ifid_pc  output  32  PC of IF/ID instruction
- ifid_instr  output  32  IF/ID instruction word
- ifid_pc_plus4  output  32  ifid_pc + 4, modulo 2^32

## Operation
- Registers: pc, state, IF/ID (valid/pc/instr), one-entry skid buffer (buf_valid/buf_instr).
- States:
  - FETCH: imem_req_valid=1, imem_req_addr=pc. If imem_req_ready, go to WAIT.
  - WAIT: one request outstanding. On imem_resp_valid:
    - if IF/ID can load (stall=0 or ifid_valid=0): load IF/ID with {1, pc, resp_data}, set pc<=pc+4, go to FETCH.
    - else: capture into buffer, go to HOLD.
  - HOLD: imem_req_valid=0. When IF/ID can load: move buffer into IF/ID, clear buffer, set pc<=pc+4, go to FETCH.
  - DRAIN: one stale request outstanding, imem_req_valid=0. On imem_resp_valid: discard the response, go to FETCH.
- IF/ID update when stall=0 and no new instruction is available: ifid_valid<=0 (bubble). ifid_pc and ifid_instr hold.
- IF/ID update when stall=1: all IF/ID fields hold.
- Redirect takes priority over stall and over every state action:
  - set pc<=redirect_pc with bits [1:0] forced to 0;
  - set ifid_valid<=0 and buf_valid<=0;
  - the response arriving in the redirect cycle is discarded.
- Next state on redirect:
  - If a request is outstanding after the cycle, go to DRAIN. This covers WAIT without resp_valid, FETCH with req_ready, and DRAIN without resp_valid.
  - Otherwise go to FETCH.
- In FETCH with redirect but no ready: imem_req_addr switches to the new pc on the next cycle. The imem contract permits an address change on redirect.
- PC arithmetic is 32-bit wrapping: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Invariants: at most one outstanding request; imem_resp_valid outside WAIT/DRAIN is ignored.

## Timing
- Reset values:
  - pc=RESET_PC, state=FETCH, buf_valid=0
  - ifid_valid=0, ifid_pc=0, ifid_instr=32'h0000_0013 (NOP), ifid_pc_plus4=4
  - imem_req_valid=0 while reset=1
- First request: imem_req_valid=1 in the first cycle after reset deasserts.
- Best-case throughput is one instruction per 2 cycles:
  - cycle N: request accepted;
  - cycle N+1: response arrives;
  - ifid_valid=1 from cycle N+2.
- Redirect latency: the next request carries the target address one cycle after redirect_valid when no request is outstanding. Otherwise it follows the cycle in which the stale response arrives.
- ifid_* are registered outputs. imem_req_valid and imem_req_addr decode from registered state and pc only, with no input-to-output path.
- Reset asserted mid-operation returns all state to reset values on the next edge. A response to a pre-reset request arriving after reset is ignored, because state is FETCH.

## Test plan
- Reset, RESET_PC=0, memory always ready with 1-cycle response; instructions 0x00500093, 0x00A00113 -> ifid_pc=0 then 4, in order, each ifid_valid pulse one cycle.
- stall=1 for 5 cycles while WAIT receives 0x00000033 at pc=8 -> IF/ID holds previous entry, no new request issued, HOLD; after stall=0, IF/ID={pc=8, 0x00000033} next cycle, then request to 12.
- redirect_valid with redirect_pc=0x100 while request at 0x10 outstanding -> ifid_valid=0 next cycle, stale response discarded, next request addr=0x100, first delivered ifid_pc=0x100.
- redirect and stall=1 in the same cycle -> ifid_valid=0 next cycle, pc=0x200; redirect_pc=0x203 -> request addr 0x200.
- imem_req_ready held low for 4 cycles -> imem_req_valid and imem_req_addr stable throughout, ifid_valid=0 bubbles.
- pc=0xFFFF_FFFC fetch -> ifid_pc_plus4=0 and next request addr=0; reset pulsed during WAIT -> all outputs back to reset values, late response ignored.
